// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: instruction constants, branch-predictor counter
// encodings and the default fetch reset vector.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam int          DEFAULT_RESET_PC = 0;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Saturating 2-bit counter step; bit 1 of the result is the taken prediction.
    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        ctr_e n;
        n = c;
        case (c)
            CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/fetch_stage_bp_btb.sv
// Direct-mapped branch target buffer with 2-bit counters: one combinational
// lookup port and one synchronous training port.
module bp_btb
    import fetch_stage_pkg::*;
#(
    parameter int PC_BITS = 12,
    parameter int ENTRIES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_BITS-1:0] i_lookup_pc,
    output logic               o_lookup_taken,
    output logic [PC_BITS-1:0] o_lookup_target,
    input  logic               i_upd_en,
    input  logic [PC_BITS-1:0] i_upd_pc,
    input  logic               i_upd_taken,
    input  logic [PC_BITS-1:0] i_upd_target
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_BITS - IDX - 2;

    logic               r_valid  [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [PC_BITS-1:0] r_target [ENTRIES];
    ctr_e               r_ctr    [ENTRIES];

    logic [IDX-1:0]     w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic               w_lk_hit;
    logic [IDX-1:0]     w_up_idx;
    logic [TAG_W-1:0]   w_up_tag;
    logic               w_up_hit;

    assign w_lk_idx = i_lookup_pc[IDX+1:2];
    assign w_lk_tag = i_lookup_pc[PC_BITS-1:IDX+2];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    // Lookup reads register state only, so a same-cycle write is seen next cycle.
    assign o_lookup_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
    assign o_lookup_target = o_lookup_taken ? r_target[w_lk_idx] : '0;

    assign w_up_idx = i_upd_pc[IDX+1:2];
    assign w_up_tag = i_upd_pc[PC_BITS-1:IDX+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_WNT;
            end
        end else if (i_upd_en) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= ctr_next(r_ctr[w_up_idx], i_upd_taken);
                if (i_upd_taken) begin
                    r_target[w_up_idx] <= i_upd_target;
                end
            end else if (i_upd_taken) begin
                // Allocation replaces whatever lived at this index.
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= i_upd_target;
                r_ctr[w_up_idx]    <= CTR_WT;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: architectural PC register, next-PC selection and BTB-based
// prediction feeding the fetch-to-decode pipeline register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                 XLEN        = 32,
    parameter int                 PC_BITS     = 12,
    parameter int                 BTB_ENTRIES = 16,
    parameter logic [PC_BITS-1:0] RESET_PC    = PC_BITS'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_D,
    input  logic               MEM_stall,
    input  logic               EX_taken,
    input  logic [PC_BITS-1:0] EX_target_pc,
    input  logic               EX_is_branch,
    input  logic [PC_BITS-1:0] EX_pc,
    input  logic               EX_br_taken,
    input  logic [PC_BITS-1:0] EX_br_target,
    output logic [PC_BITS-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic [PC_BITS-1:0] F_pc,
    output logic [XLEN-1:0]    F_inst,
    output logic               F_BP_taken,
    output logic [PC_BITS-1:0] F_BP_target_pc
);

    logic [PC_BITS-1:0] r_pc;
    logic [PC_BITS-1:0] w_next_pc;
    logic               w_bp_taken;
    logic [PC_BITS-1:0] w_bp_target;
    logic               w_train_en;

    assign w_train_en = EX_is_branch && !MEM_stall;

    bp_btb #(
        .PC_BITS (PC_BITS),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk             (clk),
        .rst             (rst),
        .i_lookup_pc     (r_pc),
        .o_lookup_taken  (w_bp_taken),
        .o_lookup_target (w_bp_target),
        .i_upd_en        (w_train_en),
        .i_upd_pc        (EX_pc),
        .i_upd_taken     (EX_br_taken),
        .i_upd_target    (EX_br_target)
    );

    // A redirect from EX wins even over stalls; the stalled stages simply refetch.
    always_comb begin
        w_next_pc = r_pc + PC_BITS'(4);
        if (EX_taken) begin
            w_next_pc = EX_target_pc;
        end else if (stall_D || MEM_stall) begin
            w_next_pc = r_pc;
        end else if (w_bp_taken) begin
            w_next_pc = w_bp_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign imem_addr      = r_pc;
    assign F_pc           = r_pc;
    assign F_inst         = imem_rdata;
    assign F_BP_taken     = w_bp_taken;
    assign F_BP_target_pc = w_bp_target;

endmodule
